rob_commit_queue: RTL and testbench

- Reorder buffer for the out-of-order core. It is the consuming end of the metadata {valid, rob_addr} tag that travels through the execute pipeline registers.
- Dispatch allocates in-order entries and receives a rob_addr tag.
- The execute completion stage returns the tag together with its result.
- The block retires completed entries strictly in program order, one per cycle, onto a registered architectural-writeback port.

---
 rtl/rob_commit_queue_if.sv | 43 ++++
 rtl/rob_commit_queue.sv | 124 ++++++++++++
 tb/tb_rob_commit_queue.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_queue_if
//  Description : Dispatch, completion and commit signal bundle of the ROB.
//  Revision    : 1.0
// ============================================================================
interface rob_commit_queue_if #(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 16,
   parameter int RF_ADDR_W = 4
);
   logic                 flush;
   logic                 alloc_req;
   logic                 alloc_write_dst;
   logic [RF_ADDR_W-1:0] alloc_rw_addr;
   logic                 alloc_ready;
   logic [ADDR_W-1:0]    alloc_rob_addr;
   logic                 cmp_valid;
   logic [ADDR_W-1:0]    cmp_rob_addr;
   logic [DATA_W-1:0]    cmp_data;
   logic                 commit_valid;
   logic [ADDR_W-1:0]    commit_rob_addr;
   logic                 commit_write;
   logic [RF_ADDR_W-1:0] commit_rw_addr;
   logic [DATA_W-1:0]    commit_data;
   logic                 empty;
   logic                 cmp_err;

   modport master (
      output flush, alloc_req, alloc_write_dst, alloc_rw_addr,
             cmp_valid, cmp_rob_addr, cmp_data,
      input  alloc_ready, alloc_rob_addr, commit_valid, commit_rob_addr,
             commit_write, commit_rw_addr, commit_data, empty, cmp_err
   );

   modport slave (
      input  flush, alloc_req, alloc_write_dst, alloc_rw_addr,
             cmp_valid, cmp_rob_addr, cmp_data,
      output alloc_ready, alloc_rob_addr, commit_valid, commit_rob_addr,
             commit_write, commit_rw_addr, commit_data, empty, cmp_err
   );
endinterface
`default_nettype wire

// File: rtl/rob_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_queue
//  Description : Reorder buffer; allocates in order, completes out of order,
//                retires in program order one entry per cycle.
//  Revision    : 1.0
// ============================================================================
module rob_commit_queue #(
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 16,
   parameter int RF_ADDR_W = 4
) (
   input  wire logic         clk,
   input  wire logic         n_rst,
   rob_commit_queue_if.slave bus
);
   localparam logic [ADDR_W:0] c_FULL = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0]    r_head;
   logic [ADDR_W-1:0]    r_tail;
   logic [ADDR_W:0]      r_count;
   logic [DEPTH-1:0]     r_busy;
   logic [DEPTH-1:0]     r_done;
   logic [DEPTH-1:0]     r_wdst;
   logic [RF_ADDR_W-1:0] r_rw   [DEPTH];
   logic [DATA_W-1:0]    r_data [DEPTH];

   logic                 r_commit_valid;
   logic [ADDR_W-1:0]    r_commit_addr;
   logic                 r_commit_write;
   logic [RF_ADDR_W-1:0] r_commit_rw;
   logic [DATA_W-1:0]    r_commit_data;
   logic                 r_cmp_err;

   logic w_alloc_ready;
   logic w_alloc;
   logic w_cmp_open;
   logic w_cmp_ok;
   logic w_cmp_bad;
   logic w_commit;

   assign w_alloc_ready = (r_count < c_FULL);
   assign w_alloc       = bus.alloc_req && w_alloc_ready && !bus.flush;
   // A completion is legal only for an allocated entry that has not yet produced a result.
   assign w_cmp_open    = r_busy[bus.cmp_rob_addr] && !r_done[bus.cmp_rob_addr];
   assign w_cmp_ok      = bus.cmp_valid && !bus.flush && w_cmp_open;
   assign w_cmp_bad     = bus.cmp_valid && !bus.flush && !w_cmp_open;
   assign w_commit      = !bus.flush && r_busy[r_head] && r_done[r_head];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_busy         <= '0;
         r_done         <= '0;
         r_commit_valid <= 1'b0;
         r_commit_addr  <= '0;
         r_commit_write <= 1'b0;
         r_commit_rw    <= '0;
         r_commit_data  <= '0;
         r_cmp_err      <= 1'b0;
      end else if (bus.flush) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_busy         <= '0;
         r_done         <= '0;
         r_commit_valid <= 1'b0;
      end else begin
         // Alloc never targets the head while full, and a completion never
         // targets a committing head, so these bit updates cannot collide.
         if (w_alloc) begin
            r_busy[r_tail] <= 1'b1;
            r_done[r_tail] <= 1'b0;
            r_tail         <= r_tail + 1'b1;
         end
         if (w_cmp_ok) begin
            r_done[bus.cmp_rob_addr] <= 1'b1;
         end
         if (w_cmp_bad) begin
            r_cmp_err <= 1'b1;
         end
         r_commit_valid <= w_commit;
         if (w_commit) begin
            r_busy[r_head] <= 1'b0;
            r_done[r_head] <= 1'b0;
            r_head         <= r_head + 1'b1;
            r_commit_addr  <= r_head;
            r_commit_write <= r_wdst[r_head];
            r_commit_rw    <= r_rw[r_head];
            r_commit_data  <= r_data[r_head];
         end
         case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage is only meaningful while busy, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_alloc) begin
         r_wdst[r_tail] <= bus.alloc_write_dst;
         r_rw[r_tail]   <= bus.alloc_rw_addr;
      end
      if (w_cmp_ok) begin
         r_data[bus.cmp_rob_addr] <= bus.cmp_data;
      end
   end

   assign bus.alloc_ready     = w_alloc_ready;
   assign bus.alloc_rob_addr  = r_tail;
   assign bus.empty           = (r_count == '0);
   assign bus.cmp_err         = r_cmp_err;
   assign bus.commit_valid    = r_commit_valid;
   assign bus.commit_rob_addr = r_commit_addr;
   assign bus.commit_write    = r_commit_write;
   assign bus.commit_rw_addr  = r_commit_rw;
   assign bus.commit_data     = r_commit_data;
endmodule
`default_nettype wire

// File: tb/tb_rob_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit_queue
//  Description : Self-checking bench for rob_commit_queue against a queue model.
//  Revision    : 1.0
// ============================================================================
module tb_rob_commit_queue;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rob_commit_queue_if #(.ADDR_W(3), .DATA_W(16), .RF_ADDR_W(4)) bus ();

   rob_commit_queue #(.DEPTH(DEPTH), .ADDR_W(3), .DATA_W(16), .RF_ADDR_W(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Program-order model: entry 0 of the queue is the oldest instruction.
   typedef struct {
      int tag;
      bit w;
      int rw;
      bit done;
      int data;
   } ent_t;

   ent_t q[$];
   ent_t m_e;
   int   m_head = 0;
   int   m_idx;
   bit   m_commit;
   int   e_cv = 0, e_tag = 0, e_w = 0, e_rw = 0, e_data = 0, e_err = 0;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q.delete();
         m_head = 0;
         e_cv = 0; e_tag = 0; e_w = 0; e_rw = 0; e_data = 0; e_err = 0;
      end else if (bus.flush) begin
         q.delete();
         m_head = 0;
         e_cv = 0;
      end else begin
         m_commit = (q.size() > 0) && q[0].done;
         if (bus.cmp_valid) begin
            m_idx = (int'(bus.cmp_rob_addr) - m_head + DEPTH) % DEPTH;
            if (m_idx < q.size() && !q[m_idx].done) begin
               m_e      = q[m_idx];
               m_e.done = 1'b1;
               m_e.data = int'(bus.cmp_data);
               q[m_idx] = m_e;
            end else begin
               e_err = 1;
            end
         end
         if (bus.alloc_req && q.size() < DEPTH) begin
            m_e.tag  = (m_head + q.size()) % DEPTH;
            m_e.w    = bus.alloc_write_dst;
            m_e.rw   = int'(bus.alloc_rw_addr);
            m_e.done = 1'b0;
            m_e.data = 0;
            q.push_back(m_e);
         end
         e_cv = m_commit ? 1 : 0;
         if (m_commit) begin
            m_e    = q.pop_front();
            e_tag  = m_e.tag;
            e_w    = m_e.w ? 1 : 0;
            e_rw   = m_e.rw;
            e_data = m_e.data;
            m_head = (m_head + 1) % DEPTH;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle compare against the model, shortly after every rising edge.
   always @(posedge clk) begin
      #1;
      chk("m_commit_valid", 32'(bus.commit_valid), e_cv);
      chk("m_commit_tag",   32'(bus.commit_rob_addr), e_tag);
      chk("m_commit_write", 32'(bus.commit_write), e_w);
      chk("m_commit_rw",    32'(bus.commit_rw_addr), e_rw);
      chk("m_commit_data",  32'(bus.commit_data), e_data);
      chk("m_cmp_err",      32'(bus.cmp_err), e_err);
      chk("m_alloc_ready",  32'(bus.alloc_ready), (q.size() < DEPTH) ? 1 : 0);
      chk("m_alloc_tag",    32'(bus.alloc_rob_addr), (m_head + q.size()) % DEPTH);
      chk("m_empty",        32'(bus.empty), (q.size() == 0) ? 1 : 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush           = 1'b0;
      bus.alloc_req       = 1'b0;
      bus.alloc_write_dst = 1'b0;
      bus.alloc_rw_addr   = '0;
      bus.cmp_valid       = 1'b0;
      bus.cmp_rob_addr    = '0;
      bus.cmp_data        = '0;
   endtask

   task automatic do_reset();
      idle();
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   task automatic do_alloc(input logic w, input logic [3:0] rw, input logic [2:0] exp_tag);
      bus.alloc_req       = 1'b1;
      bus.alloc_write_dst = w;
      bus.alloc_rw_addr   = rw;
      chk("grant_tag", 32'(bus.alloc_rob_addr), 32'(exp_tag));
      tick();
      bus.alloc_req = 1'b0;
   endtask

   task automatic do_cmp(input logic [2:0] tag, input logic [15:0] d);
      bus.cmp_valid    = 1'b1;
      bus.cmp_rob_addr = tag;
      bus.cmp_data     = d;
      tick();
      bus.cmp_valid = 1'b0;
   endtask

   int n_commits;

   initial begin
      idle();
      do_reset();
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_ready", 32'(bus.alloc_ready), 1);
      chk("rst_tag",   32'(bus.alloc_rob_addr), 0);
      chk("rst_cv",    32'(bus.commit_valid), 0);
      chk("rst_data",  32'(bus.commit_data), 0);

      // 1: out-of-order completion, in-order retirement
      do_alloc(1'b1, 4'd1, 3'd0);
      do_alloc(1'b1, 4'd2, 3'd1);
      do_alloc(1'b1, 4'd3, 3'd2);
      do_cmp(3'd2, 16'h0022);
      chk("t1_no_early", 32'(bus.commit_valid), 0);
      do_cmp(3'd0, 16'h0000);
      chk("t1_no_early2", 32'(bus.commit_valid), 0);
      do_cmp(3'd1, 16'h0011);
      chk("t1_c0_valid", 32'(bus.commit_valid), 1);
      chk("t1_c0_tag",   32'(bus.commit_rob_addr), 0);
      chk("t1_c0_rw",    32'(bus.commit_rw_addr), 1);
      tick();
      chk("t1_c1_tag",   32'(bus.commit_rob_addr), 1);
      chk("t1_c1_data",  32'(bus.commit_data), 32'h0011);
      tick();
      chk("t1_c2_tag",   32'(bus.commit_rob_addr), 2);
      chk("t1_c2_rw",    32'(bus.commit_rw_addr), 3);
      chk("t1_c2_data",  32'(bus.commit_data), 32'h0022);
      tick();
      chk("t1_idle_cv",  32'(bus.commit_valid), 0);
      chk("t1_hold",     32'(bus.commit_data), 32'h0022);
      chk("t1_empty",    32'(bus.empty), 1);

      // 2: fill, refuse when full, wrap the tag
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_alloc(1'b0, 4'(i), 3'(i));
      chk("t2_full_ready", 32'(bus.alloc_ready), 0);
      do_alloc(1'b1, 4'hF, 3'd0);
      chk("t2_still_full", 32'(bus.alloc_ready), 0);
      do_cmp(3'd0, 16'h1234);
      tick();
      chk("t2_commit0", 32'(bus.commit_valid), 1);
      chk("t2_ready",   32'(bus.alloc_ready), 1);
      chk("t2_empty",   32'(bus.empty), 0);
      do_alloc(1'b1, 4'd9, 3'd0);

      // 3: single-entry latency
      do_reset();
      do_alloc(1'b1, 4'd7, 3'd0);
      do_cmp(3'd0, 16'hABCD);
      chk("t3_edgeN", 32'(bus.commit_valid), 0);
      tick();
      chk("t3_cv",    32'(bus.commit_valid), 1);
      chk("t3_tag",   32'(bus.commit_rob_addr), 0);
      chk("t3_data",  32'(bus.commit_data), 32'hABCD);
      chk("t3_empty", 32'(bus.empty), 1);
      tick();
      chk("t3_cv_low", 32'(bus.commit_valid), 0);

      // 4: illegal completions
      do_reset();
      do_cmp(3'd5, 16'h5555);
      chk("t4_err_unalloc", 32'(bus.cmp_err), 1);
      chk("t4_no_commit",   32'(bus.commit_valid), 0);
      tick();
      chk("t4_sticky", 32'(bus.cmp_err), 1);
      do_reset();
      chk("t4_err_cleared", 32'(bus.cmp_err), 0);
      do_alloc(1'b1, 4'd4, 3'd0);
      do_alloc(1'b1, 4'd5, 3'd1);
      do_cmp(3'd1, 16'h1111);
      chk("t4_no_err", 32'(bus.cmp_err), 0);
      do_cmp(3'd1, 16'h2222);
      chk("t4_err_double", 32'(bus.cmp_err), 1);
      do_cmp(3'd0, 16'h0101);
      tick();
      tick();
      chk("t4_keep_data", 32'(bus.commit_data), 32'h1111);
      chk("t4_err_held",  32'(bus.cmp_err), 1);

      // 5: flush drops everything in its cycle
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(1'b1, 4'(i), 3'(i));
      do_cmp(3'd2, 16'h0202);
      bus.flush        = 1'b1;
      bus.alloc_req    = 1'b1;
      bus.cmp_valid    = 1'b1;
      bus.cmp_rob_addr = 3'd0;
      bus.cmp_data     = 16'hDEAD;
      tick();
      idle();
      chk("t5_empty", 32'(bus.empty), 1);
      chk("t5_tag",   32'(bus.alloc_rob_addr), 0);
      chk("t5_cv",    32'(bus.commit_valid), 0);
      tick();
      tick();
      chk("t5_quiet", 32'(bus.commit_valid), 0);
      do_alloc(1'b0, 4'd3, 3'd0);

      // 6: sustained alloc/complete/commit, then asynchronous reset
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_alloc(1'(i % 2), 4'(i), 3'(i));
      n_commits = 0;
      for (int k = 0; k < 20; k++) begin
         bus.alloc_req       = 1'b1;
         bus.alloc_write_dst = 1'(k % 2);
         bus.alloc_rw_addr   = 4'(k);
         bus.cmp_valid       = 1'b1;
         bus.cmp_rob_addr    = 3'(k % DEPTH);
         bus.cmp_data        = 16'(k);
         tick();
         if (bus.commit_valid) n_commits++;
      end
      chk("t6_commits",   32'(n_commits), 19);
      chk("t6_last_tag",  32'(bus.commit_rob_addr), 2);
      chk("t6_last_data", 32'(bus.commit_data), 32'h12);
      chk("t6_no_err",    32'(bus.cmp_err), 0);
      #3;
      n_rst = 1'b0;
      #1;
      chk("t6_rst_cv",    32'(bus.commit_valid), 0);
      chk("t6_rst_data",  32'(bus.commit_data), 0);
      chk("t6_rst_empty", 32'(bus.empty), 1);
      chk("t6_rst_ready", 32'(bus.alloc_ready), 1);
      chk("t6_rst_tag",   32'(bus.alloc_rob_addr), 0);
      idle();
      tick();
      n_rst = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
